fifoc2cs: RTL and testbench

FIFOC2CS -- requirements
Module: fifoc2cs

---
 rtl/fifoc2cs.sv | 134 +++++++++++++
 tb/tb_fifoc2cs.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifoc2cs.sv
// Command-frame reader: drains one fixed-length frame from fifoc and checks its header and checksum.
// Decoded fields are latched only when the whole frame checks out.
module fifoc2cs #(
    parameter int unsigned FRAME_LEN = 12,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fs,
    output logic       fd,
    output logic       err,
    input  logic       fifo_empty,
    output logic       fifo_rxen,
    input  logic [7:0] fifo_rxd,
    output logic [7:0] kind_dev,
    output logic [7:0] info_sr,
    output logic [7:0] cmd_filt,
    output logic [7:0] cmd_mix0,
    output logic [7:0] cmd_mix1,
    output logic [7:0] cmd_reg4,
    output logic [7:0] cmd_reg5,
    output logic [7:0] cmd_reg6,
    output logic [7:0] cmd_reg7
);
    localparam int unsigned NPAY = 9;
    localparam int unsigned TW   = $clog2(TIMEOUT + 1);
    localparam logic [7:0]    HDR0    = 8'h55;
    localparam logic [7:0]    HDR1    = 8'hAA;
    localparam logic [3:0]    LAST    = 4'(FRAME_LEN - 1);
    localparam logic [3:0]    NPAY4   = 4'(NPAY);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, READ, CHECK, DONE} state_t;

    state_t               state;
    logic                 pending;
    logic [3:0]           cnt;
    logic [3:0]           pidx;
    logic [7:0]           sum;
    logic [7:0]           chk;
    logic [TW-1:0]        to_cnt;
    logic [NPAY-1:0][7:0] shadow;

    // Only one read in flight: the byte arrives the cycle after fifo_rxen.
    assign fifo_rxen = (state == READ) && !fifo_empty && !pending;
    assign pidx      = cnt - 4'd2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fd       <= 1'b0;
            err      <= 1'b0;
            pending  <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            chk      <= '0;
            to_cnt   <= '0;
            shadow   <= '0;
            kind_dev <= '0;
            info_sr  <= '0;
            cmd_filt <= '0;
            cmd_mix0 <= '0;
            cmd_mix1 <= '0;
            cmd_reg4 <= '0;
            cmd_reg5 <= '0;
            cmd_reg6 <= '0;
            cmd_reg7 <= '0;
        end else begin
            pending <= fifo_rxen;
            case (state)
                IDLE: begin
                    if (fs) begin
                        state  <= READ;
                        cnt    <= '0;
                        sum    <= '0;
                        to_cnt <= '0;
                        err    <= 1'b0;
                    end
                end
                READ: begin
                    if (pending) begin
                        cnt    <= cnt + 4'd1;
                        to_cnt <= '0;
                        if (cnt == 4'd0) begin
                            if (fifo_rxd != HDR0) err <= 1'b1;
                        end else if (cnt == 4'd1) begin
                            if (fifo_rxd != HDR1) err <= 1'b1;
                        end else if (cnt == LAST) begin
                            chk   <= fifo_rxd;
                            state <= CHECK;
                        end else if (pidx < NPAY4) begin
                            shadow[pidx] <= fifo_rxd;
                            sum          <= sum + fifo_rxd;
                        end
                    end else if (fifo_empty) begin
                        // Starved: give up on the frame and report it as bad.
                        if (to_cnt == TO_LAST) begin
                            to_cnt <= TW'(TIMEOUT);
                            err    <= 1'b1;
                            fd     <= 1'b1;
                            state  <= DONE;
                        end else begin
                            to_cnt <= to_cnt + TW'(1);
                        end
                    end
                end
                CHECK: begin
                    if (!err && (chk == sum)) begin
                        kind_dev <= shadow[0];
                        info_sr  <= shadow[1];
                        cmd_filt <= shadow[2];
                        cmd_mix0 <= shadow[3];
                        cmd_mix1 <= shadow[4];
                        cmd_reg4 <= shadow[5];
                        cmd_reg5 <= shadow[6];
                        cmd_reg6 <= shadow[7];
                        cmd_reg7 <= shadow[8];
                    end else begin
                        err <= 1'b1;
                    end
                    fd    <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    if (!fs) begin
                        fd    <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifoc2cs.sv
`timescale 1ns/1ps
// Bench for fifoc2cs: a byte-queue FIFO model feeds frames; predicted err and decoded
// fields are queued at stimulus time and compared when fd rises.
module tb_fifoc2cs;
    localparam int FRAME_LEN = 12;
    localparam int TIMEOUT   = 1023;

    typedef logic [7:0] frame_t [FRAME_LEN];
    typedef struct packed {
        logic        err;
        logic [71:0] outs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        fs;
    logic        fd;
    logic        err;
    logic        fifo_empty = 1'b1;
    logic        fifo_rxen;
    logic [7:0]  fifo_rxd = 8'h00;
    logic [7:0]  kind_dev, info_sr, cmd_filt, cmd_mix0, cmd_mix1;
    logic [7:0]  cmd_reg4, cmd_reg5, cmd_reg6, cmd_reg7;
    logic [71:0] outs;

    logic [7:0]  fifo_q[$];
    exp_t        exp_q[$];
    logic [71:0] model_outs = '0;
    int unsigned cyc = 0;
    int unsigned pops = 0;
    int unsigned last_pop_cyc = 0;
    int unsigned start_cyc = 0;
    int unsigned bad_reads = 0;
    bit          burst = 1'b0;
    bit          gate = 1'b0;
    bit          take;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    fifoc2cs dut (
        .clk(clk), .rst(rst), .fs(fs), .fd(fd), .err(err),
        .fifo_empty(fifo_empty), .fifo_rxen(fifo_rxen), .fifo_rxd(fifo_rxd),
        .kind_dev(kind_dev), .info_sr(info_sr), .cmd_filt(cmd_filt),
        .cmd_mix0(cmd_mix0), .cmd_mix1(cmd_mix1), .cmd_reg4(cmd_reg4),
        .cmd_reg5(cmd_reg5), .cmd_reg6(cmd_reg6), .cmd_reg7(cmd_reg7)
    );

    assign outs = {kind_dev, info_sr, cmd_filt, cmd_mix0, cmd_mix1,
                   cmd_reg4, cmd_reg5, cmd_reg6, cmd_reg7};

    // FIFO model: read data appears just after the edge that sampled fifo_rxen.
    always begin
        @(posedge clk);
        cyc  = cyc + 1;
        take = fifo_rxen;
        #1;
        if (take) begin
            if (fifo_q.size() == 0) bad_reads = bad_reads + 1;
            else fifo_rxd = fifo_q.pop_front();
            pops         = pops + 1;
            last_pop_cyc = cyc;
        end
        gate       = burst && !gate;
        fifo_empty = (fifo_q.size() == 0) || gate;
    end

    function automatic frame_t mk_frame(input logic [71:0] p, input logic [7:0] h1,
                                        input logic [7:0] adj);
        frame_t     f;
        logic [7:0] s;
        s    = '0;
        f[0] = 8'h55;
        f[1] = h1;
        for (int i = 0; i < 9; i++) begin
            f[2+i] = p[71-8*i -: 8];
            s      = s + f[2+i];
        end
        f[FRAME_LEN-1] = s + adj;
        return f;
    endfunction

    task automatic start_frame(input frame_t f, input int nbytes, output int unsigned base);
        exp_t       e;
        logic [7:0] s;
        for (int i = 0; i < nbytes; i++) fifo_q.push_back(f[i]);
        s = '0;
        for (int i = 2; i < FRAME_LEN - 1; i++) s = s + f[i];
        e.err  = 1'b1;
        e.outs = model_outs;
        if (nbytes == FRAME_LEN && f[0] == 8'h55 && f[1] == 8'hAA && f[FRAME_LEN-1] == s) begin
            e.err  = 1'b0;
            e.outs = {f[2], f[3], f[4], f[5], f[6], f[7], f[8], f[9], f[10]};
        end
        model_outs = e.outs;
        exp_q.push_back(e);
        repeat (2) @(negedge clk);
        base      = pops;
        fs        = 1'b1;
        start_cyc = cyc + 1;
    endtask

    task automatic wait_done(input int unsigned limit, output bit seen);
        seen = 1'b0;
        for (int unsigned i = 0; i < limit; i++) begin
            @(negedge clk);
            if (fd === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fs  = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (fd !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b expected 0", fd); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        n_checks++; if (fifo_rxen !== 1'b0) begin n_fail++; $display("FAIL reset_rxen: got %b expected 0", fifo_rxen); end
        n_checks++; if (outs !== 72'h0) begin n_fail++; $display("FAIL reset_outs: got %h expected 0", outs); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_frame(input string name, input frame_t f, input bit bursty);
        exp_t        e;
        bit          seen;
        int unsigned base;
        int unsigned lat;
        burst = bursty;
        start_frame(f, FRAME_LEN, base);
        wait_done(80, seen);
        lat = cyc - start_cyc;
        n_checks++; if (!seen) begin n_fail++; $display("FAIL %s_done: fd=%b, expected 1 within 80 cycles", name, fd); end
        if (!bursty) begin
            n_checks++;
            if (lat > 2 * FRAME_LEN + 2) begin n_fail++; $display("FAIL %s_latency: got %0d cycles, limit %0d", name, lat, 2 * FRAME_LEN + 2); end
        end
        e = exp_q.pop_front();
        n_checks++; if (err !== e.err) begin n_fail++; $display("FAIL %s_err: got %b expected %b", name, err, e.err); end
        n_checks++; if (outs !== e.outs) begin n_fail++; $display("FAIL %s_outs: got %h expected %h", name, outs, e.outs); end
        n_checks++; if (pops - base != FRAME_LEN || bad_reads != 0) begin
            n_fail++; $display("FAIL %s_consumed: got %0d reads (%0d from empty) expected %0d", name, pops - base, bad_reads, FRAME_LEN);
        end
        fs    = 1'b0;
        burst = 1'b0;
        @(negedge clk);
        n_checks++; if (fd !== 1'b0) begin n_fail++; $display("FAIL %s_fd_fall: got %b expected 0", name, fd); end
    endtask

    task automatic test_good_frame();
        frame_t f;
        f = '{8'h55, 8'hAA, 8'h01, 8'h04, 8'h02, 8'h10, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h37};
        test_frame("good", f, 1'b0);
        n_checks++;
        if (kind_dev !== 8'h01 || info_sr !== 8'h04 || cmd_filt !== 8'h02 || cmd_mix0 !== 8'h10 || cmd_mix1 !== 8'h20) begin
            n_fail++; $display("FAIL good_fields: got %h %h %h %h %h expected 01 04 02 10 20", kind_dev, info_sr, cmd_filt, cmd_mix0, cmd_mix1);
        end
    endtask

    task automatic test_bad_checksum();
        test_frame("bad_cks", mk_frame(72'h01_04_02_10_20_00_00_00_00, 8'hAA, 8'h01), 1'b0);
    endtask

    task automatic test_bad_header();
        test_frame("bad_hdr", mk_frame(72'h11_22_33_44_55_66_77_88_99, 8'hAB, 8'h00), 1'b0);
    endtask

    task automatic test_bursty();
        test_frame("bursty", mk_frame(72'hA1_B2_C3_D4_E5_F6_07_18_29, 8'hAA, 8'h00), 1'b1);
    endtask

    task automatic test_starved();
        frame_t      f;
        exp_t        e;
        bit          ok;
        int unsigned base;
        int unsigned p;
        f = mk_frame(72'h5A_5A_5A_5A_5A_5A_5A_5A_5A, 8'hAA, 8'h00);
        start_frame(f, 5, base);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pops - base == 5) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL starve_reads: got %0d reads expected 5", pops - base); end
        p = last_pop_cyc;
        for (int i = 0; i < 1200 && cyc < p + TIMEOUT; i++) @(negedge clk);
        n_checks++; if (fd !== 1'b0) begin n_fail++; $display("FAIL starve_early: fd=%b at cycle %0d after last read, expected 0", fd, cyc - p); end
        @(negedge clk);
        n_checks++; if (fd !== 1'b1) begin n_fail++; $display("FAIL starve_fd: fd=%b at cycle %0d after last read, expected 1", fd, cyc - p); end
        e = exp_q.pop_front();
        n_checks++; if (err !== e.err) begin n_fail++; $display("FAIL starve_err: got %b expected %b", err, e.err); end
        n_checks++; if (outs !== e.outs) begin n_fail++; $display("FAIL starve_outs: got %h expected %h", outs, e.outs); end
        n_checks++; if (bad_reads != 0 || pops - base != 5) begin n_fail++; $display("FAIL starve_extra: got %0d reads (%0d from empty) expected 5", pops - base, bad_reads); end
        fs = 1'b0;
        @(negedge clk);
        n_checks++; if (fd !== 1'b0) begin n_fail++; $display("FAIL starve_fd_fall: got %b expected 0", fd); end
    endtask

    task automatic test_reset_midframe();
        int unsigned base;
        bit          ok;
        start_frame(mk_frame(72'h0F_1E_2D_3C_4B_5A_69_78_87, 8'hAA, 8'h00), FRAME_LEN, base);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pops - base == 6) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL midrst_reads: got %0d reads expected 6", pops - base); end
        @(negedge clk);
        rst = 1'b1;
        fs  = 1'b0;
        @(negedge clk);
        n_checks++; if (fd !== 1'b0) begin n_fail++; $display("FAIL midrst_fd: got %b expected 0", fd); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b expected 0", err); end
        n_checks++; if (fifo_rxen !== 1'b0) begin n_fail++; $display("FAIL midrst_rxen: got %b expected 0", fifo_rxen); end
        n_checks++; if (outs !== 72'h0) begin n_fail++; $display("FAIL midrst_outs: got %h expected 0", outs); end
        void'(exp_q.pop_back());
        model_outs = '0;
        rst        = 1'b0;
        fifo_q.delete();
        @(negedge clk);
        test_frame("post_rst", mk_frame(72'h01_04_02_10_20_00_00_00_00, 8'hAA, 8'h00), 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [71:0] p;
        for (int n = 0; n < 3; n++) begin
            p = {$urandom(), $urandom(), $urandom()};
            test_frame("b2b", mk_frame(p, 8'hAA, 8'h00), 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_bad_header();
        test_bursty();
        test_starved();
        test_reset_midframe();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
